// File: rtl/hsp_result_collector.sv
// Drains the Blastn_Array ungapped-HSP FIFO, drops low-score or empty hits,
// packs kept hits into 32-bit words and buffers them in a show-ahead FIFO for the host.
module hsp_result_collector #(
    parameter int LENGTH_COUNTER = 8,
    parameter int SCORE_MIN      = 8,
    parameter int DEPTH          = 16,
    parameter int ADDR_W         = 4
) (
    input  logic                        array_clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic                        clear,
    input  logic                        FIFO_empty,
    output logic                        read_HSP,
    input  logic [LENGTH_COUNTER-1:0]   hit_add_inQ_UnGap,
    input  logic [LENGTH_COUNTER-1:0]   hit_add_inS_UnGap,
    input  logic [LENGTH_COUNTER-1:0]   hit_length_UnGap,
    input  logic [LENGTH_COUNTER-1:0]   hit_add_score,
    input  logic                        out_rd,
    output logic [4*LENGTH_COUNTER-1:0] out_data,
    output logic                        out_valid,
    output logic                        out_full,
    output logic [15:0]                 hsp_count,
    output logic [15:0]                 drop_count,
    output logic                        done
);

    localparam logic [LENGTH_COUNTER-1:0] SCORE_MIN_L = LENGTH_COUNTER'(SCORE_MIN);
    localparam logic [ADDR_W:0]           FULL_COUNT  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, EVAL} state_t;

    state_t state, next_state;

    logic [LENGTH_COUNTER-1:0]   cap_q, cap_s, cap_len, cap_score;
    logic [4*LENGTH_COUNTER-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]           wr_ptr, rd_ptr;
    logic [ADDR_W:0]             count;
    logic                        keep_hit, wr_en, drop_en, rd_en;

    assign keep_hit  = (cap_len != '0) && (cap_score >= SCORE_MIN_L);
    assign out_valid = (count != '0);
    assign out_full  = (count == FULL_COUNT);
    assign rd_en     = out_rd && out_valid;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // A kept hit waits in EVAL while the output FIFO is full, so nothing is lost
    always_comb begin
        next_state = state;
        wr_en      = 1'b0;
        drop_en    = 1'b0;
        case (state)
            IDLE: if (enable && !FIFO_empty) next_state = REQ;
            REQ:  next_state = WAIT;
            WAIT: next_state = EVAL;
            EVAL: begin
                if (!keep_hit) begin
                    drop_en    = 1'b1;
                    next_state = IDLE;
                end else if (!out_full) begin
                    wr_en      = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge array_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            read_HSP <= 1'b0;
            done     <= 1'b0;
        end else if (clear) begin
            state    <= IDLE;
            read_HSP <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= next_state;
            read_HSP <= (next_state == REQ);
            done     <= enable && FIFO_empty && (state == IDLE);
        end
    end

    // Hit fields are only valid in the cycle after read_HSP
    always_ff @(posedge array_clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_q     <= '0;
            cap_s     <= '0;
            cap_len   <= '0;
            cap_score <= '0;
        end else if (clear) begin
            cap_q     <= '0;
            cap_s     <= '0;
            cap_len   <= '0;
            cap_score <= '0;
        end else if (state == WAIT) begin
            cap_q     <= hit_add_inQ_UnGap;
            cap_s     <= hit_add_inS_UnGap;
            cap_len   <= hit_length_UnGap;
            cap_score <= hit_add_score;
        end
    end

    always_ff @(posedge array_clk) begin
        if (wr_en && !clear) mem[wr_ptr] <= {cap_score, cap_len, cap_s, cap_q};
    end

    always_ff @(posedge array_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge array_clk or negedge reset_n) begin
        if (!reset_n) begin
            hsp_count  <= '0;
            drop_count <= '0;
        end else if (clear) begin
            hsp_count  <= '0;
            drop_count <= '0;
        end else begin
            if (wr_en && hsp_count != 16'hFFFF)    hsp_count  <= hsp_count + 16'd1;
            if (drop_en && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_hsp_result_collector.sv
// Directed self-checking bench for hsp_result_collector with a queue-based
// model of the array HSP FIFO that answers read_HSP one cycle later.
module tb_hsp_result_collector;

    logic        array_clk;
    logic        reset_n;
    logic        enable;
    logic        clear;
    logic        FIFO_empty;
    logic        read_HSP;
    logic [7:0]  hit_add_inQ_UnGap;
    logic [7:0]  hit_add_inS_UnGap;
    logic [7:0]  hit_length_UnGap;
    logic [7:0]  hit_add_score;
    logic        out_rd;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_full;
    logic [15:0] hsp_count;
    logic [15:0] drop_count;
    logic        done;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int read_count = 0;
    logic [31:0] hit_q[$];

    hsp_result_collector #(
        .LENGTH_COUNTER(8), .SCORE_MIN(8), .DEPTH(16), .ADDR_W(4)
    ) dut (
        .array_clk(array_clk),
        .reset_n(reset_n),
        .enable(enable),
        .clear(clear),
        .FIFO_empty(FIFO_empty),
        .read_HSP(read_HSP),
        .hit_add_inQ_UnGap(hit_add_inQ_UnGap),
        .hit_add_inS_UnGap(hit_add_inS_UnGap),
        .hit_length_UnGap(hit_length_UnGap),
        .hit_add_score(hit_add_score),
        .out_rd(out_rd),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_full(out_full),
        .hsp_count(hsp_count),
        .drop_count(drop_count),
        .done(done)
    );

    initial begin
        array_clk = 1'b0;
        forever #5 array_clk = ~array_clk;
    end

    // Array FIFO model: on a read_HSP cycle, present the next hit from mid-cycle on
    initial begin
        FIFO_empty        = 1'b1;
        hit_add_inQ_UnGap = '0;
        hit_add_inS_UnGap = '0;
        hit_length_UnGap  = '0;
        hit_add_score     = '0;
        forever begin
            @(negedge array_clk);
            if (read_HSP === 1'b1) begin
                read_count++;
                if (hit_q.size() > 0)
                    {hit_add_score, hit_length_UnGap, hit_add_inS_UnGap, hit_add_inQ_UnGap} = hit_q.pop_front();
            end
            FIFO_empty = (hit_q.size() == 0);
        end
    end

    task automatic applyStimulus(input logic [7:0] q, input logic [7:0] s,
                                 input logic [7:0] len, input logic [7:0] score);
        hit_q.push_back({score, len, s, q});
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic waitRead(input string tag);
        int n = 0;
        while (read_HSP !== 1'b1 && n < 200) begin
            @(negedge array_clk);
            n++;
        end
        checkOutput(tag, 32'(read_HSP), 32'd1);
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge array_clk);
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        @(negedge array_clk);
        clear = 1'b0;
    endtask

    function automatic logic [31:0] bpWord(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {8'h20 + b, 8'h01, 8'h40 + b, b};
    endfunction

    initial begin
        int base;
        int n;
        reset_n = 1'b0;
        enable  = 1'b0;
        clear   = 1'b0;
        out_rd  = 1'b0;

        // Reset values
        waitCycles(3);
        checkOutput("rst_read",  32'(read_HSP),  32'd0);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_full",  32'(out_full),  32'd0);
        checkOutput("rst_done",  32'(done),      32'd0);
        checkOutput("rst_hsp",   32'(hsp_count), 32'd0);
        checkOutput("rst_drop",  32'(drop_count),32'd0);
        checkOutput("rst_data",  out_data,       32'd0);
        reset_n = 1'b1;
        waitCycles(2);

        // Keep path and latency
        base = read_count;
        applyStimulus(8'h10, 8'h20, 8'h0B, 8'h0C);
        enable = 1'b1;
        waitRead("keep_req");
        @(negedge array_clk);
        checkOutput("keep_valid_c1", 32'(out_valid), 32'd0);
        @(negedge array_clk);
        checkOutput("keep_valid_c2", 32'(out_valid), 32'd0);
        @(negedge array_clk);
        checkOutput("keep_valid_c3", 32'(out_valid), 32'd1);
        checkOutput("keep_data",     out_data,       32'h0C0B2010);
        checkOutput("keep_hsp",      32'(hsp_count), 32'd1);
        waitCycles(4);
        checkOutput("keep_one_pulse", 32'(read_count - base), 32'd1);
        checkOutput("keep_done",      32'(done), 32'd1);
        out_rd = 1'b1;
        @(negedge array_clk);
        out_rd = 1'b0;
        checkOutput("keep_popped", 32'(out_valid), 32'd0);

        // Clear while idle, then filter
        pulseClear();
        checkOutput("clr_hsp", 32'(hsp_count), 32'd0);
        applyStimulus(8'h01, 8'h02, 8'h03, 8'h05);
        waitRead("drop_req");
        waitCycles(4);
        checkOutput("drop_cnt1",  32'(drop_count), 32'd1);
        checkOutput("drop_hsp",   32'(hsp_count),  32'd0);
        checkOutput("drop_valid", 32'(out_valid),  32'd0);
        applyStimulus(8'h05, 8'h06, 8'h00, 8'hFF);
        waitRead("drop_len0_req");
        waitCycles(4);
        checkOutput("drop_cnt2", 32'(drop_count), 32'd2);
        applyStimulus(8'h07, 8'h08, 8'h01, 8'h08);
        waitRead("min_score_req");
        waitCycles(4);
        checkOutput("min_score_kept", 32'(hsp_count), 32'd1);
        out_rd = 1'b1;
        @(negedge array_clk);
        out_rd = 1'b0;

        // Backpressure: 17 kept hits, no reads
        pulseClear();
        base = read_count;
        for (int i = 0; i < 17; i++) hit_q.push_back(bpWord(i));
        waitCycles(100);
        checkOutput("bp_full",  32'(out_full),  32'd1);
        checkOutput("bp_hsp16", 32'(hsp_count), 32'd16);
        checkOutput("bp_reads", 32'(read_count - base), 32'd17);
        checkOutput("bp_head",  out_data, bpWord(0));
        checkOutput("bp_done",  32'(done), 32'd0);
        waitCycles(10);
        checkOutput("bp_no_more_reads", 32'(read_count - base), 32'd17);
        out_rd = 1'b1;
        @(negedge array_clk);
        out_rd = 1'b0;
        checkOutput("bp_after_pop_full", 32'(out_full),  32'd0);
        checkOutput("bp_after_pop_hsp",  32'(hsp_count), 32'd16);
        @(negedge array_clk);
        checkOutput("bp_refill_full", 32'(out_full),  32'd1);
        checkOutput("bp_hsp17",       32'(hsp_count), 32'd17);
        for (int k = 1; k <= 16; k++) begin
            checkOutput($sformatf("bp_drain%0d", k), out_data, bpWord(k));
            out_rd = 1'b1;
            @(negedge array_clk);
        end
        @(negedge array_clk);
        out_rd = 1'b0;
        checkOutput("bp_empty", 32'(out_valid), 32'd0);
        checkOutput("bp_empty_hsp", 32'(hsp_count), 32'd17);

        // Clear in WAIT, then restart on the following cycle
        applyStimulus(8'hA1, 8'hA2, 8'h04, 8'h50);
        applyStimulus(8'h33, 8'h44, 8'h05, 8'h99);
        waitRead("clrw_req");
        @(negedge array_clk);
        clear = 1'b1;
        @(negedge array_clk);
        clear = 1'b0;
        checkOutput("clrw_hsp",   32'(hsp_count),  32'd0);
        checkOutput("clrw_drop",  32'(drop_count), 32'd0);
        checkOutput("clrw_valid", 32'(out_valid),  32'd0);
        checkOutput("clrw_idle_read", 32'(read_HSP), 32'd0);
        @(negedge array_clk);
        checkOutput("clrw_restart", 32'(read_HSP), 32'd1);
        waitCycles(4);
        checkOutput("clrw_data", out_data, 32'h99054433);
        checkOutput("clrw_hsp1", 32'(hsp_count), 32'd1);
        out_rd = 1'b1;
        @(negedge array_clk);
        out_rd = 1'b0;

        // Idle with empty array FIFO
        for (int i = 0; i < 20; i++) begin
            @(negedge array_clk);
            checkOutput($sformatf("idle_read%0d", i), 32'(read_HSP), 32'd0);
            checkOutput($sformatf("idle_done%0d", i), 32'(done), 32'd1);
        end

        // Asynchronous reset in EVAL with 3 words stored
        pulseClear();
        for (int i = 0; i < 4; i++) applyStimulus(8'(i), 8'h11, 8'h02, 8'h40);
        n = 0;
        for (int i = 0; i < 100 && n < 4; i++) begin
            @(negedge array_clk);
            if (read_HSP === 1'b1) n++;
        end
        checkOutput("ar_reads", 32'(n), 32'd4);
        waitCycles(2);
        checkOutput("ar_pre_hsp", 32'(hsp_count), 32'd3);
        reset_n = 1'b0;
        #1;
        checkOutput("ar_valid", 32'(out_valid), 32'd0);
        checkOutput("ar_data",  out_data,       32'd0);
        checkOutput("ar_hsp",   32'(hsp_count), 32'd0);
        checkOutput("ar_read",  32'(read_HSP),  32'd0);
        checkOutput("ar_done",  32'(done),      32'd0);
        checkOutput("ar_full",  32'(out_full),  32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
